// File: rtl/tx_frame_sequencer.sv
// UART transmit frame sequencer: latches a byte, builds an 11-bit frame, shifts it out LSB-first.
// Optional parity generation is enabled by defining TX_PARITY_EN.
module tx_frame_sequencer #(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [7:0]        out_port,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] baud_k,
    output logic              tx,
    output logic              txrdy,
    output logic              tx_done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

    localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);

    state_t            r_state;
    logic [7:0]        r_ldata;
    logic              r_eight;
    logic [BAUD_W-1:0] r_k;
    logic [BAUD_W-1:0] r_timer;
    logic [3:0]        r_bitcnt;
    logic [10:0]       r_sr;
    logic              r_fin;
    logic              r_tx;
    logic              r_txrdy;
    logic              r_tx_done;

    logic w_nine;
    logic w_ten;
    logic w_btu;

`ifdef TX_PARITY_EN
    logic r_pen;
    logic r_ohel;

    assign w_nine = r_eight ? r_ldata[7] : (r_pen ? ((^r_ldata[6:0]) ^ r_ohel) : 1'b1);
    assign w_ten  = (r_eight && r_pen) ? ((^r_ldata) ^ r_ohel) : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pen  <= 1'b0;
            r_ohel <= 1'b0;
        end else if (r_state == S_IDLE && load && r_txrdy) begin
            r_pen  <= pen;
            r_ohel <= ohel;
        end
    end
`else
    logic w_unused;

    assign w_unused = pen ^ ohel;
    assign w_nine   = r_eight ? r_ldata[7] : 1'b1;
    assign w_ten    = 1'b1;
`endif

    assign w_btu = (r_state == S_SEND) && (r_timer == r_k - ONE);

    // tx/txrdy/tx_done are registered one cycle behind the shifter, so the
    // start bit appears two edges after the accepted load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ldata   <= 8'h00;
            r_eight   <= 1'b0;
            r_k       <= '0;
            r_timer   <= '0;
            r_bitcnt  <= 4'd0;
            r_sr      <= '1;
            r_fin     <= 1'b0;
            r_tx      <= 1'b1;
            r_txrdy   <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_fin     <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx      <= (r_state == S_SEND) ? r_sr[0] : 1'b1;
            if (r_fin) begin
                r_txrdy   <= 1'b1;
                r_tx_done <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (load && r_txrdy) begin
                        r_ldata <= out_port;
                        r_eight <= eight;
                        r_k     <= (baud_k == '0) ? ONE : baud_k;
                        r_txrdy <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_sr     <= {1'b1, w_ten, w_nine, r_ldata[6:0], 1'b0};
                    r_timer  <= '0;
                    r_bitcnt <= 4'd0;
                    r_state  <= S_SEND;
                end
                S_SEND: begin
                    if (w_btu) begin
                        r_sr    <= {1'b1, r_sr[10:1]};
                        r_timer <= '0;
                        if (r_bitcnt == 4'd10) begin
                            r_bitcnt <= 4'd0;
                            r_fin    <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end else begin
                        r_timer <= r_timer + ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx      = r_tx;
    assign txrdy   = r_txrdy;
    assign tx_done = r_tx_done;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: directed vector table plus random frames against a frame-level model.
module tb_tx_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  out_port = 8'h00;
    logic        eight = 1'b0;
    logic        pen = 1'b0;
    logic        ohel = 1'b0;
    logic [18:0] baud_k = 19'd0;
    logic        tx;
    logic        txrdy;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

`ifdef TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    tx_frame_sequencer #(.BAUD_W(19)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .out_port(out_port),
        .eight(eight), .pen(pen), .ohel(ohel), .baud_k(baud_k),
        .tx(tx), .txrdy(txrdy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        e;
        logic        p;
        logic        o;
        logic [18:0] k;
        logic [10:0] frame_par;
        logic [10:0] frame_nopar;
        int          junk;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got {tx,txrdy,tx_done}=%b want %b", name, act, exp);
        end
    endtask

    // Frame from the framing rules: start, 7 data bits, bit9, bit10, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                                input logic p, input logic o);
        int  ones7 = $countones(d[6:0]);
        int  ones8 = $countones(d);
        bit  pe = p && PAR_EN;
        logic nine, ten;
        if (!e) begin
            nine = pe ? (((ones7 % 2) == 1) ^ o) : 1'b1;
            ten  = 1'b1;
        end else begin
            nine = d[7];
            ten  = pe ? (((ones8 % 2) == 1) ^ o) : 1'b1;
        end
        return {1'b1, ten, nine, d[6:0], 1'b0};
    endfunction

    // Called just after a falling edge; load is sampled at the next rising edge (edge n).
    // Checks every cycle through edge n+2+11k and one idle cycle after.
    task automatic run_frame(input string name, input logic [7:0] d, input logic e,
                             input logic p, input logic o, input logic [18:0] bk,
                             input logic [10:0] frame, input int junk_at, input int rst_at);
        int kk   = (bk == 19'd0) ? 1 : int'(bk);
        int last = 2 + 11 * kk;
        logic [2:0] exp;
        out_port = d; eight = e; pen = p; ohel = o; baud_k = bk; load = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= last + 1; j++) begin
            @(negedge clk);
            if (j == 0 || j == junk_at + 1) load = 1'b0;
            if (j == 0) begin
                out_port = 8'($urandom); eight = 1'($urandom); pen = 1'($urandom);
                ohel = 1'($urandom); baud_k = 19'($urandom_range(0, 50));
            end
            if (j == junk_at) begin
                load = 1'b1;
                out_port = 8'hFF;
            end
            if (j < 2)          exp = 3'b100;
            else if (j < last)  exp = {frame[(j - 2) / kk], 2'b00};
            else if (j == last) exp = 3'b111;
            else                exp = 3'b110;
            chk($sformatf("%s_c%0d", name, j), {tx, txrdy, tx_done}, exp);
            if (j == rst_at) begin
                load = 1'b0;
                reset_n = 1'b0;
                #1;
                chk({name, "_rst_now"}, {tx, txrdy, tx_done}, 3'b110);
                repeat (3) begin
                    @(negedge clk);
                    chk({name, "_rst_hold"}, {tx, txrdy, tx_done}, 3'b110);
                end
                reset_n = 1'b1;
                for (int m = 0; m < 2 * kk + 20; m++) begin
                    @(negedge clk);
                    chk({name, "_rst_after"}, {tx, txrdy, tx_done}, 3'b110);
                end
                return;
            end
        end
        load = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 19'd4, 11'b10010101010, 11'b11010101010, 10};
        vecs[1] = '{8'h03, 1'b0, 1'b1, 1'b1, 19'd3, 11'b11100000110, 11'b11100000110, -1};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 19'd0, 11'b11100000000, 11'b11100000000, -1};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 19'd0, 11'b11000000000, 11'b11100000000, 12};
        vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b1, 19'd2, 11'b11101001010, 11'b11101001010, 23};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b0, 19'd5, 11'b10110000110, 11'b11110000110, 0};

        repeat (3) @(negedge clk);
        chk("reset", {tx, txrdy, tx_done}, 3'b110);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle", {tx, txrdy, tx_done}, 3'b110);
        end

        foreach (vecs[i])
            run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].e, vecs[i].p, vecs[i].o,
                      vecs[i].k, PAR_EN ? vecs[i].frame_par : vecs[i].frame_nopar,
                      vecs[i].junk, -1);

        // Reset at bit 5 of a k=3 frame, then a clean frame afterwards.
        run_frame("midrst", 8'hA5, 1'b1, 1'b1, 1'b1, 19'd3,
                  model_frame(8'hA5, 1'b1, 1'b1, 1'b1), -1, 2 + 5 * 3);
        run_frame("afterrst", 8'hA5, 1'b1, 1'b1, 1'b1, 19'd3,
                  model_frame(8'hA5, 1'b1, 1'b1, 1'b1), -1, -1);

        for (int r = 0; r < 30; r++) begin
            logic [7:0]  d  = 8'($urandom);
            logic        e  = 1'($urandom);
            logic        p  = 1'($urandom);
            logic        o  = 1'($urandom);
            logic [18:0] bk = 19'($urandom_range(0, 6));
            int          kk = (bk == 19'd0) ? 1 : int'(bk);
            int          jk = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 1 + 11 * kk));
            run_frame($sformatf("rnd%0d", r), d, e, p, o, bk, model_frame(d, e, p, o), jk, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
